// File: rtl/cpu_pkg.sv
// Shared CPU types: register-file address/data widths, the x0 constant and the
// write-back queue entry.
package cpu_pkg;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned XLEN   = 32;

    localparam logic [REG_AW-1:0] REG_X0 = '0;

    typedef struct packed {
        logic [REG_AW-1:0] wa;
        logic [XLEN-1:0]   wd;
    } wb_entry_t;
endpackage

// File: rtl/wb_bypass_match.sv
// Newest-match search for one register read port over the pending
// write-back entries and the register-file output stage.
module wb_bypass_match
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  wb_entry_t [DEPTH-1:0]        entries,
    input  logic [$clog2(DEPTH)-1:0]     rd_ptr,
    input  logic [$clog2(DEPTH):0]       count,
    input  logic                         rf_we,
    input  logic [REG_AW-1:0]            rf_wa,
    input  logic [XLEN-1:0]              rf_wd,
    input  logic [REG_AW-1:0]            ra,
    output logic                         hit,
    output logic [XLEN-1:0]              data
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic              acc_hit;
    logic [XLEN-1:0]   acc_data;
    logic [PW-1:0]     idx;

    // Walk oldest to newest so the last match found is the newest write.
    always_comb begin
        acc_hit  = rf_we && (rf_wa == ra);
        acc_data = rf_wd;
        idx      = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if ((CW'(k) < count) && (entries[idx].wa == ra)) begin
                acc_hit  = 1'b1;
                acc_data = entries[idx].wd;
            end
        end
    end

    assign hit  = acc_hit && (ra != REG_X0);
    assign data = hit ? acc_data : '0;
endmodule

// File: rtl/wb_queue.sv
// Write-back queue: merges ALU and load results (ALU first) into a circular
// FIFO drained one entry per cycle into a registered register-file write port.
// Define WB_BYPASS_EN to enable the pending-write forwarding to ra1/ra2.
module wb_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [REG_AW-1:0]        alu_wa,
    input  logic [XLEN-1:0]          alu_wd,
    output logic                     alu_ready,
    input  logic                     ld_valid,
    input  logic [REG_AW-1:0]        ld_wa,
    input  logic [XLEN-1:0]          ld_wd,
    output logic                     ld_ready,
    output logic                     rf_we,
    output logic [REG_AW-1:0]        rf_wa,
    output logic [XLEN-1:0]          rf_wd,
    input  logic [REG_AW-1:0]        ra1,
    input  logic [REG_AW-1:0]        ra2,
    output logic                     byp1_hit,
    output logic [XLEN-1:0]          byp1_data,
    output logic                     byp2_hit,
    output logic [XLEN-1:0]          byp2_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  push;
    logic                  pop;
    wb_entry_t             push_entry;

    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign count     = cnt;
    assign alu_ready = !full;
    assign ld_ready  = !full && !alu_valid;
    assign pop       = !empty;

    // Writes to x0 complete the handshake but are dropped here.
    always_comb begin
        push       = 1'b0;
        push_entry = '{wa: ld_wa, wd: ld_wd};
        if (alu_valid && alu_ready) begin
            push       = (alu_wa != REG_X0);
            push_entry = '{wa: alu_wa, wd: alu_wd};
        end else if (ld_valid && ld_ready) begin
            push       = (ld_wa != REG_X0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            rf_we  <= 1'b0;
            rf_wa  <= '0;
            rf_wd  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            rf_we <= pop;
            if (pop) begin
                rf_wa <= mem[rd_ptr].wa;
                rf_wd <= mem[rd_ptr].wd;
            end
        end
    end

    // Entry storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

`ifdef WB_BYPASS_EN
    wb_bypass_match #(.DEPTH(DEPTH)) u_byp1 (
        .entries (mem),
        .rd_ptr  (rd_ptr),
        .count   (cnt),
        .rf_we   (rf_we),
        .rf_wa   (rf_wa),
        .rf_wd   (rf_wd),
        .ra      (ra1),
        .hit     (byp1_hit),
        .data    (byp1_data)
    );

    wb_bypass_match #(.DEPTH(DEPTH)) u_byp2 (
        .entries (mem),
        .rd_ptr  (rd_ptr),
        .count   (cnt),
        .rf_we   (rf_we),
        .rf_wa   (rf_wa),
        .rf_wd   (rf_wd),
        .ra      (ra2),
        .hit     (byp2_hit),
        .data    (byp2_data)
    );
`else
    logic unused_ra;
    assign unused_ra = ^{ra1, ra2};
    assign byp1_hit  = 1'b0;
    assign byp1_data = '0;
    assign byp2_hit  = 1'b0;
    assign byp2_data = '0;
`endif
endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: directed pushes queue their expected rf
// writes with a due cycle; a negedge monitor checks every rf write.
`timescale 1ns/1ps
module tb_wb_queue;
    import cpu_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef WB_BYPASS_EN
    localparam logic BYP_ON = 1'b1;
`else
    localparam logic BYP_ON = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              alu_valid;
    logic [REG_AW-1:0] alu_wa;
    logic [XLEN-1:0]   alu_wd;
    logic              alu_ready;
    logic              ld_valid;
    logic [REG_AW-1:0] ld_wa;
    logic [XLEN-1:0]   ld_wd;
    logic              ld_ready;
    logic              rf_we;
    logic [REG_AW-1:0] rf_wa;
    logic [XLEN-1:0]   rf_wd;
    logic [REG_AW-1:0] ra1;
    logic [REG_AW-1:0] ra2;
    logic              byp1_hit;
    logic [XLEN-1:0]   byp1_data;
    logic              byp2_hit;
    logic [XLEN-1:0]   byp2_data;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_wa    (alu_wa),
        .alu_wd    (alu_wd),
        .alu_ready (alu_ready),
        .ld_valid  (ld_valid),
        .ld_wa     (ld_wa),
        .ld_wd     (ld_wd),
        .ld_ready  (ld_ready),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .ra1       (ra1),
        .ra2       (ra2),
        .byp1_hit  (byp1_hit),
        .byp1_data (byp1_data),
        .byp2_hit  (byp2_hit),
        .byp2_data (byp2_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned tick = 0;
    always @(posedge clk) tick++;

    typedef struct {
        logic [REG_AW-1:0] wa;
        logic [XLEN-1:0]   wd;
        int unsigned       due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (tick %0d)", name, act, req, tick);
        end
    endfunction

    // Monitor: every rf write must match the oldest expectation on its due cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due < tick) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missed_write: got none, want wa=%0d wd=0x%0h at tick %0d", mon_e.wa, mon_e.wd, mon_e.due);
        end
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0 || exp_q[0].due != tick) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_write: got wa=%0d wd=0x%0h at tick %0d, want none", rf_wa, rf_wd, tick);
            end else begin
                mon_e = exp_q.pop_front();
                check("rf_wa", 32'(rf_wa), 32'(mon_e.wa));
                check("rf_wd", rf_wd, mon_e.wd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at drive time: accepted at next edge, written one edge later.
    task automatic expect_wr(input logic [REG_AW-1:0] wa, input logic [XLEN-1:0] wd);
        exp_q.push_back('{wa: wa, wd: wd, due: tick + 2});
    endtask

    task automatic drive_alu(input logic v, input logic [REG_AW-1:0] wa, input logic [XLEN-1:0] wd);
        alu_valid = v;
        alu_wa    = wa;
        alu_wd    = wd;
    endtask

    task automatic drive_ld(input logic v, input logic [REG_AW-1:0] wa, input logic [XLEN-1:0] wd);
        ld_valid = v;
        ld_wa    = wa;
        ld_wd    = wd;
    endtask

    logic [REG_AW-1:0] vec_wa [4] = '{5'd1, 5'd2, 5'd3, 5'd4};
    logic [XLEN-1:0]   vec_wd [4] = '{32'h100, 32'h200, 32'h300, 32'h400};

    initial begin
        rst_n = 1'b0;
        drive_alu(1'b0, '0, '0);
        drive_ld(1'b0, '0, '0);
        ra1 = 5'd3;
        ra2 = 5'd0;
        step();
        step();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_rf_wa", 32'(rf_wa), 32'd0);
        check("rst_rf_wd", rf_wd, 32'd0);
        check("rst_byp1_hit", 32'(byp1_hit), 32'd0);
        rst_n = 1'b1;
        ra1   = 5'd0;
        step();

        // Single ALU push into an empty queue.
        drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        check("single_alu_ready", 32'(alu_ready), 32'd1);
        expect_wr(5'd5, 32'hDEADBEEF);
        step();
        drive_alu(1'b0, '0, '0);
        check("single_count_1", 32'(count), 32'd1);
        check("single_empty_0", 32'(empty), 32'd0);
        step();
        check("single_count_0", 32'(count), 32'd0);
        step();
        step();
        step();
        check("hold_rf_we", 32'(rf_we), 32'd0);
        check("hold_rf_wa", 32'(rf_wa), 32'd5);
        check("hold_rf_wd", rf_wd, 32'hDEADBEEF);

        // ALU and load together: ALU wins, load follows next cycle.
        drive_alu(1'b1, 5'd7, 32'h000000A1);
        drive_ld(1'b1, 5'd9, 32'h000000B2);
        #1;
        check("prio_alu_ready", 32'(alu_ready), 32'd1);
        check("prio_ld_ready", 32'(ld_ready), 32'd0);
        expect_wr(5'd7, 32'h000000A1);
        step();
        drive_alu(1'b0, '0, '0);
        #1;
        check("prio_ld_ready_next", 32'(ld_ready), 32'd1);
        expect_wr(5'd9, 32'h000000B2);
        step();
        drive_ld(1'b0, '0, '0);
        step();
        step();
        step();

        // Four back-to-back pushes alternating ALU and load.
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                drive_alu(1'b1, vec_wa[i], vec_wd[i]);
                drive_ld(1'b0, '0, '0);
                #1;
                check("b2b_alu_ready", 32'(alu_ready), 32'd1);
            end else begin
                drive_alu(1'b0, '0, '0);
                drive_ld(1'b1, vec_wa[i], vec_wd[i]);
                #1;
                check("b2b_ld_ready", 32'(ld_ready), 32'd1);
            end
            expect_wr(vec_wa[i], vec_wd[i]);
            step();
            check("b2b_count", 32'(count), 32'd1);
            check("b2b_full", 32'(full), 32'd0);
        end
        drive_alu(1'b0, '0, '0);
        drive_ld(1'b0, '0, '0);
        step();
        step();
        step();

        // Two pending writes to x3: newest (FIFO) beats the rf stage.
        drive_alu(1'b1, 5'd3, 32'h11);
        expect_wr(5'd3, 32'h11);
        step();
        drive_alu(1'b1, 5'd3, 32'h22);
        expect_wr(5'd3, 32'h22);
        step();
        drive_alu(1'b0, '0, '0);
        ra1 = 5'd3;
        ra2 = 5'd0;
        #1;
        check("byp1_hit", 32'(byp1_hit), 32'(BYP_ON));
        check("byp1_data", byp1_data, BYP_ON ? 32'h22 : 32'h0);
        check("byp2_hit_x0", 32'(byp2_hit), 32'd0);
        check("byp2_data_x0", byp2_data, 32'd0);
        ra1 = 5'd0;
        step();
        step();
        step();

        // Write to x0: accepted, never enqueued, never written.
        drive_alu(1'b1, 5'd0, 32'h0000FFFF);
        #1;
        check("x0_alu_ready", 32'(alu_ready), 32'd1);
        step();
        drive_alu(1'b0, '0, '0);
        check("x0_count", 32'(count), 32'd0);
        check("x0_empty", 32'(empty), 32'd1);
        step();
        step();
        step();

        // Reset mid-stream discards the in-flight writes.
        drive_alu(1'b1, 5'd10, 32'hA0);
        expect_wr(5'd10, 32'hA0);
        step();
        drive_alu(1'b1, 5'd11, 32'hA1);
        expect_wr(5'd11, 32'hA1);
        step();
        drive_alu(1'b1, 5'd12, 32'hA2);
        expect_wr(5'd12, 32'hA2);
        step();
        #1;
        rst_n = 1'b0;
        drive_alu(1'b0, '0, '0);
        exp_q.delete();
        #1;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_full", 32'(full), 32'd0);
        check("midrst_rf_we", 32'(rf_we), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();

        check("drain_pending", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
